// File: rtl/arith_pkg.sv
// Shared encodings for the multi-cycle execute-stage arithmetic unit.
package arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } opcode_t;

   typedef enum logic [1:0] {
      SEL_REG_B = 2'b00,
      SEL_MEM   = 2'b01,
      SEL_IMM   = 2'b10,
      SEL_ZERO  = 2'b11
   } movi_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10
   } state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle over WIDTH cycles.
// done, quotient and remainder describe the iteration being committed on the current edge.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   shifted, trial;
   logic             fits;

   always_comb begin
      shifted   = {rem_q, quo_q[WIDTH-1]};
      trial     = shifted - {1'b0, dvs_q};
      fits      = ~trial[WIDTH];
      quotient  = {quo_q[WIDTH-2:0], fits};
      remainder = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      done      = busy && (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt_q <= '0;
         quo_q <= dividend;
         rem_q <= '0;
         dvs_q <= divisor;
      end else if (busy) begin
         quo_q <= quotient;
         rem_q <= remainder;
         cnt_q <= cnt_q + CW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/arith_unit_mc.sv
// Multi-cycle ADD/SUB/MUL/DIV unit with latched operands, BUSY handshake and status flags.
module arith_unit_mc
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ACT,
   input  logic             SIGNED,
   input  logic [1:0]       OP_CODE,
   input  logic [1:0]       MOVI,
   input  logic [WIDTH-1:0] REG_A,
   input  logic [WIDTH-1:0] REG_B,
   input  logic [WIDTH-1:0] MEM,
   input  logic [WIDTH-1:0] IMM,
   output logic             BUSY,
   output logic [WIDTH-1:0] DATA,
   output logic [WIDTH-1:0] REM,
   output logic             DATA_VALID,
   output logic             OVF,
   output logic             DZ,
   output logic             ZERO
);

   localparam int unsigned MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

   state_t           state_q, state_d;
   opcode_t          op;
   logic [WIDTH-1:0] a, b, a_mag, b_mag;
   logic             accept, div_zero, div_start, div_done;
   logic [WIDTH:0]   sum_x, diff_x;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic             mul_ovf_now, mul_last;
   logic [WIDTH-1:0] quo, rmd;

   logic [WIDTH-1:0] mul_data_q;
   logic             mul_ovf_q, div_qneg_q, div_rneg_q, div_ovf_q;
   logic [MCW-1:0]   mul_cnt_q;

   logic             fin, fin_ovf, fin_dz;
   logic [WIDTH-1:0] fin_data, fin_rem;

   always_comb begin
      op = opcode_t'(OP_CODE);
      a  = REG_A;
      unique case (movi_t'(MOVI))
         SEL_REG_B: b = REG_B;
         SEL_MEM:   b = MEM;
         SEL_IMM:   b = IMM;
         SEL_ZERO:  b = '0;
      endcase
      accept    = ACT && (state_q == S_IDLE);
      div_zero  = (b == '0);
      div_start = accept && (op == OP_DIV) && !div_zero;
      sum_x     = {1'b0, a} + {1'b0, b};
      diff_x    = {1'b0, a} - {1'b0, b};
      // Sign-extending before an unsigned multiply yields the correct low 2*WIDTH bits in both modes.
      ext_a     = {{WIDTH{SIGNED & a[WIDTH-1]}}, a};
      ext_b     = {{WIDTH{SIGNED & b[WIDTH-1]}}, b};
      prod      = ext_a * ext_b;
      mul_ovf_now = SIGNED ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                           : (prod[2*WIDTH-1:WIDTH] != '0);
      a_mag     = (SIGNED && a[WIDTH-1]) ? -a : a;
      b_mag     = (SIGNED && b[WIDTH-1]) ? -b : b;
      mul_last  = (mul_cnt_q == MCW'(MUL_LAT - 1));
   end

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (CLK),
      .rst       (RST),
      .start     (div_start),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .busy      (),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rmd)
   );

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && (op == OP_MUL) && (MUL_LAT > 1)) state_d = S_MUL;
            else if (div_start)                             state_d = S_DIV;
         end
         S_MUL:   if (mul_last) state_d = S_IDLE;
         S_DIV:   if (div_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state_q != S_IDLE);
   end

   always_comb begin
      fin      = 1'b0;
      fin_data = '0;
      fin_rem  = '0;
      fin_ovf  = 1'b0;
      fin_dz   = 1'b0;
      if (accept) begin
         unique case (op)
            OP_ADD: begin
               fin      = 1'b1;
               fin_data = sum_x[WIDTH-1:0];
               fin_ovf  = SIGNED ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum_x[WIDTH-1] != a[WIDTH-1]))
                                 : sum_x[WIDTH];
            end
            OP_SUB: begin
               fin      = 1'b1;
               fin_data = diff_x[WIDTH-1:0];
               fin_ovf  = SIGNED ? ((a[WIDTH-1] != b[WIDTH-1]) && (diff_x[WIDTH-1] != a[WIDTH-1]))
                                 : diff_x[WIDTH];
            end
            OP_MUL: begin
               if (MUL_LAT == 1) begin
                  fin      = 1'b1;
                  fin_data = prod[WIDTH-1:0];
                  fin_ovf  = mul_ovf_now;
               end
            end
            OP_DIV: begin
               if (div_zero) begin
                  fin     = 1'b1;
                  fin_rem = a;
                  fin_dz  = 1'b1;
               end
            end
         endcase
      end else if ((state_q == S_MUL) && mul_last) begin
         fin      = 1'b1;
         fin_data = mul_data_q;
         fin_ovf  = mul_ovf_q;
      end else if ((state_q == S_DIV) && div_done) begin
         fin      = 1'b1;
         fin_data = div_qneg_q ? -quo : quo;
         fin_rem  = div_rneg_q ? -rmd : rmd;
         fin_ovf  = div_ovf_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mul_data_q <= '0;
         mul_ovf_q  <= 1'b0;
         mul_cnt_q  <= '0;
         div_qneg_q <= 1'b0;
         div_rneg_q <= 1'b0;
         div_ovf_q  <= 1'b0;
      end else if (accept) begin
         mul_data_q <= prod[WIDTH-1:0];
         mul_ovf_q  <= mul_ovf_now;
         mul_cnt_q  <= '0;
         div_qneg_q <= SIGNED & (a[WIDTH-1] ^ b[WIDTH-1]);
         div_rneg_q <= SIGNED & a[WIDTH-1];
         div_ovf_q  <= SIGNED && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      end else if ((state_q == S_MUL) && !mul_last) begin
         mul_cnt_q <= mul_cnt_q + MCW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         DATA       <= '0;
         REM        <= '0;
         DATA_VALID <= 1'b0;
         OVF        <= 1'b0;
         DZ         <= 1'b0;
         ZERO       <= 1'b0;
      end else begin
         DATA_VALID <= fin;
         if (fin) begin
            DATA <= fin_data;
            REM  <= fin_rem;
            OVF  <= fin_ovf;
            DZ   <= fin_dz;
            ZERO <= (fin_data == '0);
         end
      end
   end

endmodule

// File: tb/tb_arith_unit_mc.sv
// Self-checking bench for arith_unit_mc: vector table plus multi-cycle corner sequences.
module tb_arith_unit_mc;

   localparam int W = 32;

   logic          CLK = 1'b0;
   logic          RST, ACT, SIGNED;
   logic [1:0]    OP_CODE, MOVI;
   logic [W-1:0]  REG_A, REG_B, MEM, IMM;
   logic          BUSY, DATA_VALID, OVF, DZ, ZERO;
   logic [W-1:0]  DATA, REM;

   always #5 CLK = ~CLK;

   arith_unit_mc #(.WIDTH(W), .MUL_LAT(3)) dut (
      .CLK(CLK), .RST(RST), .ACT(ACT), .SIGNED(SIGNED), .OP_CODE(OP_CODE), .MOVI(MOVI),
      .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM), .BUSY(BUSY), .DATA(DATA),
      .REM(REM), .DATA_VALID(DATA_VALID), .OVF(OVF), .DZ(DZ), .ZERO(ZERO)
   );

   typedef struct {
      logic        sgn;
      logic [1:0]  op;
      logic [1:0]  movi;
      logic [31:0] a;
      logic [31:0] opb;
      logic [31:0] data;
      logic [31:0] rem;
      logic        ovf;
      logic        dz;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [31:0] rem;
      logic        ovf;
      logic        dz;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[18];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic sgn, input logic [1:0] op, input logic [1:0] movi,
                               input logic [31:0] a, input logic [31:0] opb, input logic [31:0] data,
                               input logic [31:0] rem, input logic ovf, input logic dz, input int lat);
      vec_t v;
      v.sgn = sgn; v.op = op; v.movi = movi; v.a = a; v.opb = opb;
      v.data = data; v.rem = rem; v.ovf = ovf; v.dz = dz; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sgn, input logic [1:0] op, input logic [1:0] movi,
                        input logic [31:0] a, input logic [31:0] opb);
      SIGNED = sgn; OP_CODE = op; MOVI = movi; REG_A = a;
      REG_B = $urandom; MEM = $urandom; IMM = $urandom;
      case (movi)
         2'b00: REG_B = opb;
         2'b01: MEM = opb;
         2'b10: IMM = opb;
         default: ;
      endcase
      ACT = 1'b1;
   endtask

   task automatic push(input logic [31:0] data, input logic [31:0] rem, input logic ovf, input logic dz);
      exp_t e;
      e.data = data; e.rem = rem; e.ovf = ovf; e.dz = dz;
      sbq.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_done(input string tag);
      exp_t e;
      chk($sformatf("%s_valid", tag), DATA_VALID, 1'b1);
      if (sbq.size() == 0) begin
         chk($sformatf("%s_sb_empty", tag), 1'b1, 1'b0);
      end else begin
         e = sbq.pop_front();
         chk($sformatf("%s_data", tag), DATA, e.data);
         chk($sformatf("%s_rem", tag), REM, e.rem);
         chk($sformatf("%s_flags", tag), {OVF, DZ, ZERO}, {e.ovf, e.dz, e.data == 32'd0});
         chk($sformatf("%s_busy_end", tag), BUSY, 1'b0);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int n;
      drive(v.sgn, v.op, v.movi, v.a, v.opb);
      push(v.data, v.rem, v.ovf, v.dz);
      tick();
      ACT = 1'b0;
      REG_A = $urandom; REG_B = $urandom; MEM = $urandom; IMM = $urandom;
      OP_CODE = 2'($urandom); MOVI = 2'($urandom); SIGNED = 1'($urandom);
      chk($sformatf("%s_busy", tag), BUSY, v.lat > 0);
      n = 0;
      while (!DATA_VALID && n < 100) begin
         tick();
         n++;
      end
      chk($sformatf("%s_latency", tag), 64'(n), 64'(v.lat));
      check_done(tag);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      RST = 1'b1; ACT = 1'b0; SIGNED = 1'b0; OP_CODE = 2'b00; MOVI = 2'b00;
      REG_A = '0; REG_B = '0; MEM = '0; IMM = '0;

      vecs[0]  = mk(0, 2'b00, 2'b10, 32'd5,        32'd7,        32'd12,       32'd0,        0, 0, 0);
      vecs[1]  = mk(0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1, 0, 0);
      vecs[2]  = mk(1, 2'b01, 2'b00, 32'h80000000, 32'd1,        32'h7FFFFFFF, 32'd0,        1, 0, 0);
      vecs[3]  = mk(0, 2'b01, 2'b01, 32'd3,        32'd5,        32'hFFFFFFFE, 32'd0,        1, 0, 0);
      vecs[4]  = mk(1, 2'b00, 2'b10, 32'h7FFFFFFF, 32'd1,        32'h80000000, 32'd0,        1, 0, 0);
      vecs[5]  = mk(1, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0, 0, 0);
      vecs[6]  = mk(0, 2'b10, 2'b00, 32'h00010000, 32'h00010000, 32'd0,        32'd0,        1, 0, 3);
      vecs[7]  = mk(1, 2'b10, 2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'd0,        0, 0, 3);
      vecs[8]  = mk(0, 2'b10, 2'b10, 32'd1234,     32'd5678,     32'h006AE9BC, 32'd0,        0, 0, 3);
      vecs[9]  = mk(1, 2'b10, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1, 0, 3);
      vecs[10] = mk(0, 2'b11, 2'b00, 32'd100,      32'd7,        32'd14,       32'd2,        0, 0, 32);
      vecs[11] = mk(1, 2'b11, 2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 32);
      vecs[12] = mk(1, 2'b11, 2'b11, 32'h00001234, 32'd0,        32'd0,        32'h00001234, 0, 1, 0);
      vecs[13] = mk(1, 2'b11, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1, 0, 32);
      vecs[14] = mk(0, 2'b11, 2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        0, 0, 32);
      vecs[15] = mk(1, 2'b11, 2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        0, 0, 32);
      vecs[16] = mk(1, 2'b01, 2'b11, 32'd0,        32'd0,        32'd0,        32'd0,        0, 0, 0);
      vecs[17] = mk(0, 2'b11, 2'b00, 32'd5,        32'd9,        32'd0,        32'd5,        0, 0, 32);

      tick(); tick();
      chk("reset_data", DATA, 32'd0);
      chk("reset_rem", REM, 32'd0);
      chk("reset_flags", {BUSY, DATA_VALID, OVF, DZ, ZERO}, 5'b0);
      RST = 1'b0;

      run_vec(vecs[0], "add_imm");
      tick();
      chk("add_hold_valid", DATA_VALID, 1'b0);
      chk("add_hold_data", DATA, 32'd12);

      for (int i = 1; i < 18; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // MUL with operand change and ACT while busy; the held ADD is taken in the completion cycle.
      drive(1'b1, 2'b10, 2'b01, 32'hFFFFFFFD, 32'd7);
      push(32'hFFFFFFEB, 32'd0, 1'b0, 1'b0);
      tick();
      REG_A = 32'd9; OP_CODE = 2'b00; MOVI = 2'b10; IMM = 32'd1; SIGNED = 1'b0;
      chk("mul_busy_k", BUSY, 1'b1);
      for (int i = 1; i < 3; i++) begin
         tick();
         chk($sformatf("mul_busy_k%0d", i), {BUSY, DATA_VALID}, 2'b10);
      end
      tick();
      check_done("mul_latched");
      push(32'd10, 32'd0, 1'b0, 1'b0);
      tick();
      ACT = 1'b0;
      check_done("add_after_mul");
      tick();
      chk("after_mul_no_queue", {DATA_VALID, DATA}, {1'b0, 32'd10});

      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 2'b00, 2'b00, 32'(i * 1000), 32'(i + 17));
         push(32'(i * 1000 + i + 17), 32'd0, 1'b0, 1'b0);
         tick();
         check_done($sformatf("b2b%0d", i));
      end
      ACT = 1'b0;

      drive(1'b0, 2'b11, 2'b00, 32'd100, 32'd7);
      tick();
      ACT = 1'b0;
      repeat (9) tick();
      chk("div_mid_busy", BUSY, 1'b1);
      RST = 1'b1;
      tick();
      chk("rst_mid_data", DATA, 32'd0);
      chk("rst_mid_rem", REM, 32'd0);
      chk("rst_mid_flags", {BUSY, DATA_VALID, OVF, DZ, ZERO}, 5'b0);
      RST = 1'b0;
      drive(1'b0, 2'b00, 2'b10, 32'd40, 32'd2);
      push(32'd42, 32'd0, 1'b0, 1'b0);
      tick();
      ACT = 1'b0;
      check_done("add_after_rst");
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (DATA_VALID) cnt++;
      end
      chk("no_stale_div", 64'(cnt), 64'd0);
      chk("sb_drained", 64'(sbq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arith_unit_mc.md
Name: arith_unit_mc

Overview:
Parametrised multi-cycle arithmetic unit for the execute stage. Performs ADD/SUB/MUL/DIV on a WIDTH-bit first operand and a MOVI-selected second operand. Extends the single-width unit with:
- latched operands and a BUSY handshake
- a configurable-latency multiplier
- a bit-serial restoring divider with remainder
- signed/unsigned mode
- status flags (overflow, divide-by-zero, zero)

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
MUL_LAT, 3, multiply latency in cycles from accept edge to DATA_VALID (>=1).

Ports:
CLK  in  1  clock, all logic on rising edge.
RST  in  1  reset, synchronous, active-high.
ACT  in  1  start request; accepted only on an edge where BUSY=0.
SIGNED  in  1  1 = two's-complement operation, 0 = unsigned; latched at accept.
OP_CODE  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
MOVI  in  2  second operand select: 00 REG_B, 01 MEM, 10 IMM, 11 zero.
REG_A  in  WIDTH  first operand.
REG_B  in  WIDTH  second operand when MOVI=00.
MEM  in  WIDTH  second operand when MOVI=01.
IMM  in  WIDTH  second operand when MOVI=10.
BUSY  out  1  multi-cycle operation in flight; ACT ignored.
DATA  out  WIDTH  result (ADD/SUB sum/difference, MUL low half, DIV quotient); held until next completion.
REM  out  WIDTH  DIV remainder, 0 for other ops; held with DATA.
DATA_VALID  out  1  one-cycle pulse on completion.
OVF  out  1  ADD/SUB carry/borrow (unsigned) or signed overflow; MUL high half non-zero (unsigned) or not the sign extension of the low half (signed); DIV signed MIN/-1; held with DATA.
DZ  out  1  DIV with divisor 0; held with DATA.
ZERO  out  1  DATA==0; held with DATA.

Behaviour:
- Reset: all outputs 0, FSM to IDLE; in-flight op is aborted and never produces DATA_VALID, including reset mid-MUL/DIV.
- Accept at edge k when ACT=1 and BUSY=0. Operands, OP_CODE and SIGNED are latched at that edge; later input changes do not affect the result.
- FSM states: IDLE, MUL, DIV.
- ADD/SUB:
  - DATA, flags and DATA_VALID=1 are registered at edge k; BUSY stays 0.
  - Back-to-back every cycle is supported.
  - Result wraps modulo 2^WIDTH.
- DIV with divisor 0: completes like ADD at edge k with DATA=0, REM=REG_A, DZ=1.
- MUL:
  - If MUL_LAT=1, single-cycle like ADD.
  - Otherwise IDLE->MUL at edge k, BUSY=1 after edge k.
  - Counter runs 1..MUL_LAT-1.
  - At edge k+MUL_LAT: DATA_VALID=1, BUSY=0, ->IDLE.
- DIV (divisor non-zero):
  - IDLE->DIV at edge k.
  - Magnitudes are taken when SIGNED=1.
  - One quotient bit per cycle, WIDTH iterations.
  - At edge k+WIDTH: DATA_VALID=1, BUSY=0, ->IDLE.
  - Signed results: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed MIN / -1: DATA=MIN, REM=0, OVF=1.
- Next op after a multi-cycle op is accepted at the earliest at edge k+L+1, i.e. in the cycle DATA_VALID is high.
- ACT while BUSY=1 is dropped silently; no queueing.
- DATA_VALID is 0 on every edge without a completion; DATA/REM/flags keep their previous values.

Decomposition:
- Package arith_pkg: opcode_t (ADD/SUB/MUL/DIV), movi_t (REG_B/MEM/IMM/ZERO), state_t (IDLE/MUL/DIV).
- Sub-module seq_divider (WIDTH):
  - start/busy/done handshake.
  - Unsigned restoring divider producing quotient and remainder in WIDTH cycles.
  - Sign handling and the divide-by-zero bypass stay in the top level.
- Multiply: registered product plus delay counter in the top level. Synthesis may retime it.

Test Plan (WIDTH=32, MUL_LAT=3):
- Reset, then ACT ADD, MOVI=10, REG_A=5, IMM=7 -> after that edge DATA=12, DATA_VALID=1, BUSY=0, OVF=0. Next cycle DATA_VALID=0 with DATA still 12.
- ADD unsigned, REG_A=0xFFFFFFFF, REG_B=1 -> DATA=0, OVF=1, ZERO=1. SUB signed, 0x80000000 - 1 -> DATA=0x7FFFFFFF, OVF=1.
- MUL signed, REG_A=-3, MEM=7; change REG_A to 9 the cycle after accept -> BUSY 3 cycles, DATA_VALID at edge k+3, DATA=-21 (0xFFFFFFEB), OVF=0. ACT issued while BUSY is ignored.
- DIV unsigned 100/7 -> DATA_VALID at edge k+32, DATA=14, REM=2. DIV signed -7/2 -> DATA=-3, REM=-1. DIV by 0 (MOVI=11) -> next edge DATA=0, REM=REG_A, DZ=1.
- Signed 0x80000000 / -1 -> DATA=0x80000000, REM=0, OVF=1.
- RST asserted 10 cycles into a DIV -> all outputs 0, BUSY=0, no DATA_VALID. ADD accepted on the following edge completes normally.
